div_unit: RTL and testbench

- Multi-cycle integer divider beside the execute stage; serves DIV and DIVU.
- Execute drives start, operands and signedness, and stalls the pipeline while ready_o is low.
- On completion, execute writes {remainder, quotient} to HI/LO as result_o[63:32] / result_o[31:0].
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/div_unit_if.sv | 22 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle: operands and control in, {rem, quot} and ready out.
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock, {rem, quot} result.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                quo_neg_q, quo_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0] res_q, res_d;

  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     rsh;
  logic [DATA_W-1:0]   trial;
  logic                ge;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    abs_a = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs_b = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    // Shifted partial remainder needs one extra bit: it can exceed DATA_W bits for large divisors.
    rsh     = {rem_q, quo_q[DATA_W-1]};
    ge      = rsh >= {1'b0, dvsr_q};
    trial   = rsh[DATA_W-1:0] - dvsr_q;
    quo_fix = quo_neg_q ? -quo_q : quo_q;
    rem_fix = rem_neg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    res_d     = res_q;
    unique case (state_q)
      StFree: begin
        if (bus.start_i && !bus.annul_i) begin
          dvsr_d    = abs_b;
          quo_neg_d = bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
          rem_neg_d = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
          rem_d     = '0;
          quo_d     = abs_a;
          cnt_d     = '0;
          if (bus.opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
`ifdef DIV_EARLY_OUT_EN
            // Skip the iterations: the final-cycle sign fixup restores the original dividend.
            if (abs_a < abs_b) begin
              rem_d = abs_a;
              quo_d = '0;
              cnt_d = CntW'(DATA_W);
            end
`endif
          end
        end
      end
      StByZero: begin
        if (bus.annul_i) begin
          state_d = StFree;
        end else begin
          res_d   = '0;
          state_d = StEnd;
        end
      end
      StOn: begin
        if (bus.annul_i) begin
          state_d = StFree;
        end else if (cnt_q == CntW'(DATA_W)) begin
          res_d   = {rem_fix, quo_fix};
          state_d = StEnd;
        end else begin
          rem_d = ge ? trial : rsh[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEnd: begin
        if (!bus.start_i) begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_comb begin
    bus.ready_o  = (state_q == StEnd);
    bus.result_o = (state_q == StEnd) ? res_q : '0;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random bench for div_unit; expected {rem, quot} pushed to a scoreboard queue at issue.
module tb_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [63:0] sb[$];

  div_unit_if #(.DATA_W(32)) bif ();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (b == 32'h0) return 64'h0;
    if (sd) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic int exp_lat(input bit sd, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ua, ub;
`endif
    if (b == 32'h0) return 1;
`ifdef DIV_EARLY_OUT_EN
    ua = (sd && a[31]) ? -a : a;
    ub = (sd && b[31]) ? -b : b;
    if (ua < ub) return 1;
`endif
    return 33;
  endfunction

  // Called #1 after a rising edge; start is sampled at the following edge (E0).
  task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit drop_mid);
    int          k;
    int          lat;
    logic [63:0] held;
    lat = exp_lat(sd, a, b);
    sb.push_back(model(sd, a, b));
    bif.signed_div_i = sd;
    bif.opdata1_i    = a;
    bif.opdata2_i    = b;
    bif.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bif.opdata1_i    = ~a;
    bif.opdata2_i    = b ^ 32'h5;
    bif.signed_div_i = ~sd;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (drop_mid && k == 5) bif.start_i = 1'b0;
    end while (!bif.ready_o && k < 100);
    check("latency", 64'(k), 64'(lat));
    held = sb.pop_front();
    check("result", bif.result_o, held);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_ready", {63'h0, bif.ready_o}, 64'h1);
      check("hold_result", bif.result_o, held);
    end
    bif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("drop_ready", {63'h0, bif.ready_o}, 64'h0);
    check("drop_result", bif.result_o, 64'h0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra, rb;
    bit          rsd;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bif.signed_div_i = 1'b0;
    bif.opdata1_i    = '0;
    bif.opdata2_i    = '0;
    bif.start_i      = 1'b0;
    bif.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'h0, bif.ready_o}, 64'h0);
    check("rst_result", bif.result_o, 64'h0);
    rst = 1'b0;

    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0, 1'b0);
    run_op(1'b0, 32'h0000_1234, 32'h0000_0000, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'd3, 32'd10, 0, 1'b0);
    run_op(1'b0, 32'd3, 32'd10, 5, 1'b0);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd10, 0, 1'b0);

    // Annul mid-operation, then an immediate restart.
    bif.signed_div_i = 1'b0;
    bif.opdata1_i    = 32'd100;
    bif.opdata2_i    = 32'd7;
    bif.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bif.annul_i = 1'b1;
    bif.start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_ready", {63'h0, bif.ready_o}, 64'h0);
    check("annul_result", bif.result_o, 64'h0);
    bif.annul_i = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, 0, 1'b0);

    // Annul while idle must block acceptance.
    bif.start_i = 1'b1;
    bif.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bif.start_i = 1'b0;
    bif.annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen = seen | bif.ready_o;
    end
    check("annul_free_block", {63'h0, seen}, 64'h0);

    // Reset mid-operation, and reset winning over a simultaneous start.
    bif.opdata1_i = 32'hFFFF_FFFF;
    bif.opdata2_i = 32'h10;
    bif.start_i   = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {63'h0, bif.ready_o}, 64'h0);
    check("midrst_result", bif.result_o, 64'h0);
    bif.opdata2_i = 32'h0;
    @(posedge clk);
    #1;
    bif.start_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rststart_ready", {63'h0, bif.ready_o}, 64'h0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      rsd = 1'($urandom_range(0, 1));
      run_op(rsd, ra, rb, (i == 2) ? 0 : i % 3, i == 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
